// File: rtl/heater_ctrl.sv
// heater_ctrl: heater/fan/lamp controller with fan purge run-on after heating
// and a saturating auto-off timer; all outputs registered from next state.
module heater_ctrl #(
  parameter int TICK_CYCLES  = 50000000,
  parameter int PURGE_S      = 30,
  parameter int TIMER_STEP_S = 600,
  parameter int TIMER_MAX_S  = 3600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  key_pulse,
  output logic        power_on,
  output logic        heat_lo,
  output logic        heat_hi,
  output logic        fan_on,
  output logic        light_on,
  output logic        timer_active,
  output logic [11:0] remain_s
);
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = PURGE_S > 1 ? $clog2(PURGE_S + 1) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_STBY  = 3'd1;
  localparam logic [2:0] S_VENT  = 3'd2;
  localparam logic [2:0] S_HEAT1 = 3'd3;
  localparam logic [2:0] S_HEAT2 = 3'd4;
  localparam logic [2:0] S_PURGE = 3'd5;
  logic [2:0]    r_state, w_key_ns, w_ns;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_purge;
  logic [11:0]   r_remain, w_sat;
  logic [12:0]   w_sum;
  logic r_off_pend, r_light, r_active, r_power, r_heat_lo, r_heat_hi, r_fan;
  logic w_tick, w_pwr, w_heat, w_fan, w_light, w_timer;
  logic w_moved, w_purge_end, w_expire, w_clear, w_timer_add, w_timed_state;
  assign w_tick  = r_presc == TICK_LAST;
  assign w_pwr   = key_pulse[0];
  assign w_heat  = key_pulse[1] & ~w_pwr;
  assign w_fan   = key_pulse[2] & ~w_pwr & ~key_pulse[1];
  assign w_light = key_pulse[3] & ~w_pwr;
  assign w_timer = key_pulse[4] & ~w_pwr;
  always_comb begin
    w_key_ns = r_state;
    case (r_state)
      S_OFF:   w_key_ns = w_pwr ? S_STBY : S_OFF;
      S_STBY:  w_key_ns = w_pwr ? S_OFF : w_heat ? S_HEAT1 : w_fan ? S_VENT : S_STBY;
      S_VENT:  w_key_ns = w_pwr ? S_OFF : w_heat ? S_HEAT1 : w_fan ? S_STBY : S_VENT;
      S_HEAT1: w_key_ns = w_pwr ? S_PURGE : w_heat ? S_HEAT2 : S_HEAT1;
      S_HEAT2: w_key_ns = (w_pwr | w_heat) ? S_PURGE : S_HEAT2;
      S_PURGE: w_key_ns = (w_heat & ~r_off_pend) ? S_HEAT1 : S_PURGE;
      default: w_key_ns = S_OFF;
    endcase
  end
  // user key transitions win over purge end and timer expiry
  assign w_moved     = w_key_ns != r_state;
  assign w_purge_end = (r_state == S_PURGE) & w_tick & (r_purge == CW'(1));
  assign w_expire    = r_active & w_tick & (r_remain == 12'd1);
  assign w_ns = w_moved ? w_key_ns
              : w_purge_end ? ((r_off_pend | w_pwr) ? S_OFF : S_STBY)
              : w_expire ? ((r_state == S_VENT) ? S_STBY : S_PURGE)
              : r_state;
  assign w_clear       = (w_ns == S_OFF) | (w_ns == S_STBY) | (w_ns == S_PURGE);
  assign w_timed_state = (r_state == S_VENT) | (r_state == S_HEAT1) | (r_state == S_HEAT2);
  assign w_timer_add   = w_timer & w_timed_state & (w_ns == r_state);
  assign w_sum = {1'b0, r_remain} + 13'(TIMER_STEP_S);
  assign w_sat = (w_sum > 13'(TIMER_MAX_S)) ? 12'(TIMER_MAX_S) : w_sum[11:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_presc    <= '0;
      r_purge    <= '0;
      r_off_pend <= 1'b0;
      r_light    <= 1'b0;
      r_active   <= 1'b0;
      r_remain   <= '0;
      r_power    <= 1'b0;
      r_heat_lo  <= 1'b0;
      r_heat_hi  <= 1'b0;
      r_fan      <= 1'b0;
    end else begin
      r_state    <= w_ns;
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_purge    <= ((w_ns == S_PURGE) & (r_state != S_PURGE)) ? CW'(PURGE_S)
                  : ((r_state == S_PURGE) & w_tick) ? r_purge - 1'b1 : r_purge;
      r_off_pend <= (w_ns == S_PURGE) & (w_pwr | ((r_state == S_PURGE) & r_off_pend));
      r_light    <= (w_ns == S_OFF) ? 1'b0 : r_light ^ (w_light & (r_state != S_OFF));
      r_active   <= w_clear ? 1'b0 : w_timer_add ? 1'b1
                  : (r_active & w_tick) ? (r_remain != 12'd1) : r_active;
      r_remain   <= w_clear ? '0 : w_timer_add ? w_sat
                  : (r_active & w_tick) ? r_remain - 12'd1 : r_remain;
      r_power    <= w_ns != S_OFF;
      r_heat_lo  <= (w_ns == S_HEAT1) | (w_ns == S_HEAT2);
      r_heat_hi  <= w_ns == S_HEAT2;
      r_fan      <= w_ns inside {S_VENT, S_HEAT1, S_HEAT2, S_PURGE};
    end
  end
  assign power_on     = r_power;
  assign heat_lo      = r_heat_lo;
  assign heat_hi      = r_heat_hi;
  assign fan_on       = r_fan;
  assign light_on     = r_light;
  assign timer_active = r_active;
  assign remain_s     = r_remain;
endmodule

// File: tb/tb_heater_ctrl.sv
// tb_heater_ctrl: directed key sequences checked every cycle against a behavioural
// model of the heater controller, plus literal expectations at key points.
module tb_heater_ctrl;
  localparam int TICK = 10, PURGE = 3, STEP = 2, TMAX = 5;
  localparam int M_OFF = 0, M_STBY = 1, M_VENT = 2, M_HEAT1 = 3, M_HEAT2 = 4, M_PURGE = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] key_pulse = '0;
  logic power_on, heat_lo, heat_hi, fan_on, light_on, timer_active;
  logic [11:0] remain_s;
  int checks = 0, errors = 0;
  heater_ctrl #(.TICK_CYCLES(TICK), .PURGE_S(PURGE), .TIMER_STEP_S(STEP), .TIMER_MAX_S(TMAX)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse), .power_on(power_on), .heat_lo(heat_lo),
    .heat_hi(heat_hi), .fan_on(fan_on), .light_on(light_on), .timer_active(timer_active),
    .remain_s(remain_s)
  );
  always #5 clk = ~clk;
  int  ms = M_OFF, mcnt = 0, mpurge = 0, mrem = 0, ns;
  bit  mop = 0, mlight = 0, mact = 0, tick, p, h, f, l, t;
  always @(posedge clk) begin
    if (rst) begin
      ms = M_OFF; mcnt = 0; mpurge = 0; mrem = 0; mop = 0; mlight = 0; mact = 0;
    end else begin
      tick = (mcnt == TICK - 1);
      mcnt = tick ? 0 : mcnt + 1;
      p = key_pulse[0]; h = key_pulse[1] && !p; f = key_pulse[2] && !p && !h;
      l = key_pulse[3] && !p; t = key_pulse[4] && !p;
      ns = ms;
      if (ms == M_OFF && p) ns = M_STBY;
      else if ((ms == M_STBY || ms == M_VENT) && p) ns = M_OFF;
      else if ((ms == M_HEAT1 || ms == M_HEAT2) && p) ns = M_PURGE;
      else if (h && ms != M_OFF && !(ms == M_PURGE && mop)) ns = (ms == M_HEAT1) ? M_HEAT2 : (ms == M_HEAT2) ? M_PURGE : M_HEAT1;
      else if (f && ms == M_STBY) ns = M_VENT;
      else if (f && ms == M_VENT) ns = M_STBY;
      if (ns == ms && ms == M_PURGE && tick && mpurge == 1) ns = (mop || p) ? M_OFF : M_STBY;
      else if (ns == ms && mact && tick && mrem == 1) ns = (ms == M_VENT) ? M_STBY : M_PURGE;
      if (ns == M_PURGE && ms != M_PURGE) mpurge = PURGE;
      else if (ms == M_PURGE && tick) mpurge = mpurge - 1;
      if (ns == M_OFF || ns == M_STBY || ns == M_PURGE) begin mrem = 0; mact = 0; end
      else if (t && ns == ms) begin mrem = (mrem + STEP > TMAX) ? TMAX : mrem + STEP; mact = 1; end
      else if (mact && tick) begin mrem = mrem - 1; mact = (mrem != 0); end
      mop = (ns == M_PURGE) && (p || (ms == M_PURGE && mop));
      if (ns == M_OFF) mlight = 0;
      else if (l && ms != M_OFF) mlight = !mlight;
      ms = ns;
    end
  end
  logic [17:0] exp_v, got_v;
  always @(posedge clk) begin
    #1;
    exp_v = {ms != M_OFF, ms == M_HEAT1 || ms == M_HEAT2, ms == M_HEAT2,
             ms >= M_VENT, mlight, mact, 12'(mrem)};
    got_v = {power_on, heat_lo, heat_hi, fan_on, light_on, timer_active, remain_s};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model @%0t: got %b required %b", $time, got_v, exp_v);
    end
  end
  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask
  task automatic pulse(input logic [4:0] k);
    key_pulse = k;
    @(negedge clk);
    key_pulse = '0;
  endtask
  function automatic logic sig(input int s);
    return s == 0 ? fan_on : s == 1 ? power_on : timer_active;
  endfunction
  task automatic wait_low(input string nm, input int s, input int bound);
    int n = 0;
    while (sig(s) !== 1'b0 && n < bound) begin @(negedge clk); n++; end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: got still high after %0d cycles required low", nm, bound);
    end
  endtask
  task automatic sync_tick();
    for (int i = 0; i < 2 * TICK && mcnt != 0; i++) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 12'({power_on, heat_lo, heat_hi, fan_on, light_on, timer_active}), 12'd0);
    chk("reset_remain", remain_s, 12'd0);
    rst = 1'b0;
    pulse(5'b00010); pulse(5'b00100); pulse(5'b01000); pulse(5'b10000); pulse(5'b11110);
    chk("off_ignores_keys", 12'({power_on, fan_on, light_on, timer_active}), 12'd0);
    pulse(5'b00001);
    chk("standby_power", 12'({power_on, fan_on}), 12'b10);
    pulse(5'b00010);
    chk("heat1_out", 12'({heat_lo, heat_hi, fan_on}), 12'b101);
    pulse(5'b00010);
    chk("heat2_out", 12'({heat_lo, heat_hi, fan_on}), 12'b111);
    pulse(5'b00010);
    chk("purge_out", 12'({heat_lo, heat_hi, fan_on}), 12'b001);
    wait_low("purge_end_fan", 0, 4 * TICK);
    chk("purge_to_standby", 12'(power_on), 12'd1);
    pulse(5'b00110);
    chk("heat_beats_fan", 12'({heat_lo, heat_hi}), 12'b10);
    sync_tick();
    pulse(5'b10000); chk("timer_press1", remain_s, 12'd2);
    pulse(5'b10000); chk("timer_press2", remain_s, 12'd4);
    pulse(5'b10000); chk("timer_saturate", remain_s, 12'd5);
    wait_low("timer_expiry", 2, 7 * TICK);
    chk("expiry_to_purge", 12'({heat_lo, fan_on, remain_s[3:0]}), 12'b010000);
    wait_low("expiry_purge_end", 0, 4 * TICK);
    pulse(5'b00011);
    chk("power_beats_heat", 12'(power_on), 12'd0);
    pulse(5'b00001); pulse(5'b01000);
    chk("light_toggle_on", 12'(light_on), 12'd1);
    pulse(5'b00010); pulse(5'b00010); pulse(5'b00001);
    chk("heat2_power_purge", 12'({power_on, heat_lo, fan_on}), 12'b101);
    pulse(5'b00010);
    chk("purge_heat_ignored", 12'(heat_lo), 12'd0);
    wait_low("purge_to_off", 1, 4 * TICK);
    chk("off_light_cleared", 12'({light_on, fan_on}), 12'd0);
    pulse(5'b00001); pulse(5'b00100);
    sync_tick();
    pulse(5'b10000);
    chk("vent_timer", remain_s, 12'd2);
    pulse(5'b00010);
    chk("vent_to_heat_keeps_timer", 12'({heat_lo, timer_active, remain_s[3:0]}), 12'b110010);
    pulse(5'b00100);
    chk("heat1_fan_ignored", 12'(heat_lo), 12'd1);
    wait_low("heat_timer_expiry", 2, 4 * TICK);
    wait_low("heat_timer_purge_end", 0, 4 * TICK);
    pulse(5'b00100); pulse(5'b10000);
    chk("vent_timer_again", remain_s, 12'd2);
    wait_low("vent_timer_expiry", 2, 4 * TICK);
    chk("vent_expiry_standby", 12'({power_on, fan_on}), 12'b10);
    pulse(5'b00100); pulse(5'b10000); pulse(5'b01000);
    key_pulse = 5'b00001; rst = 1'b1;
    @(negedge clk);
    key_pulse = '0; rst = 1'b0;
    chk("rst_outputs", 12'({power_on, heat_lo, heat_hi, fan_on, light_on, timer_active}), 12'd0);
    chk("rst_remain", remain_s, 12'd0);
    pulse(5'b00001); pulse(5'b00010); pulse(5'b00001);
    repeat (TICK + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_purge", 12'({power_on, fan_on}), 12'd0);
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/heater_ctrl.md
HEATER_CTRL -- requirements
Module: heater_ctrl

Interface
REQ-001 Parameter TICK_CYCLES, default 50000000, clk cycles per 1 s tick.
REQ-002 Parameter PURGE_S, default 30, fan run-on seconds after heating stops.
REQ-003 Parameter TIMER_STEP_S, default 600, seconds added per timer key press.
REQ-004 Parameter TIMER_MAX_S, default 3600, timer saturation value; SHALL be at most 4095.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 key_pulse  in  5  debounced one-cycle key pulses: [0] power, [1] heat, [2] fan, [3] light, [4] timer.
REQ-008 power_on  out  1  unit powered (any state except OFF).
REQ-009 heat_lo  out  1  low heater stage enable.
REQ-010 heat_hi  out  1  high heater stage enable (heat_lo also 1 when heat_hi is 1).
REQ-011 fan_on  out  1  exhaust fan enable.
REQ-012 light_on  out  1  lamp enable.
REQ-013 timer_active  out  1  auto-off timer running.
REQ-014 remain_s  out  12  remaining timer seconds; 0 when the timer is inactive.

Function
REQ-015 States SHALL be OFF, STANDBY, VENT, HEAT1, HEAT2 and PURGE; all outputs SHALL be registered and decoded from registered state, so a key pulse sampled at edge N is visible after edge N.
REQ-016 Output decode SHALL be:
- OFF and STANDBY: all enables 0.
- VENT: fan_on=1.
- HEAT1: heat_lo=1, fan_on=1.
- HEAT2: heat_lo=1, heat_hi=1, fan_on=1.
- PURGE: fan_on=1.
REQ-017 Seconds prescaler SHALL count 0..TICK_CYCLES-1 and wrap; sec_tick is asserted in the cycle where count equals TICK_CYCLES-1.
REQ-018 Priority: power key set -> all other bits ignored that cycle; otherwise heat takes precedence over fan, and light/timer are processed in parallel with heat/fan.
REQ-019 OFF: power -> STANDBY; all other keys ignored.
REQ-020 Power key in STANDBY or VENT -> OFF.
REQ-021 Power key in HEAT1 or HEAT2 -> PURGE and set off_pending.
REQ-022 Power key in PURGE -> set off_pending, stay in PURGE.
REQ-023 STANDBY transitions: heat -> HEAT1; fan -> VENT.
REQ-024 VENT transitions: heat -> HEAT1; fan -> STANDBY.
REQ-025 HEAT1: heat -> HEAT2. HEAT2: heat -> PURGE. Fan key is ignored in both heat states.
REQ-026 PURGE: heat key -> HEAT1 and reloads nothing, provided off_pending=0; otherwise the heat key is ignored. Fan key is ignored.
REQ-027 Entering PURGE SHALL load purge_cnt=PURGE_S. Each sec_tick decrements purge_cnt. On the sec_tick where purge_cnt==1: go to OFF if off_pending, else STANDBY. off_pending clears on leaving PURGE.
REQ-028 Light key toggles light_on in any state except OFF; entering OFF SHALL clear light_on.
REQ-029 Timer key in VENT/HEAT1/HEAT2, with no transition that cycle, SHALL set remain_s = min(remain_s+TIMER_STEP_S, TIMER_MAX_S) and set timer_active; the add SHALL be computed 13 bits wide so there is no wrap.
REQ-030 Timer key in any other state, or in the same cycle as a state transition, SHALL be ignored.
REQ-031 While timer_active, each sec_tick decrements remain_s. On the tick where remain_s==1: remain_s=0, timer_active=0, HEAT1/HEAT2 -> PURGE (off_pending=0), VENT -> STANDBY, all on the same edge.
REQ-032 A user key transition on the expiry cycle SHALL take precedence over expiry.
REQ-033 Any transition to STANDBY, OFF or PURGE SHALL clear timer_active and remain_s; transitions among VENT/HEAT1/HEAT2 SHALL preserve the timer.

Reset
REQ-034 rst=1 at a clk edge SHALL force OFF, all outputs 0, remain_s=0, prescaler=0, purge_cnt=0 and off_pending=0, regardless of state, including mid-PURGE and mid-timer.
REQ-035 rst SHALL take priority over key_pulse in the same cycle.

Verification (TICK_CYCLES=10, PURGE_S=3, TIMER_STEP_S=2, TIMER_MAX_S=5)
REQ-036 Power, heat, heat, heat pulses -> sequence STANDBY, HEAT1 (heat_lo=1, fan_on=1), HEAT2 (heat_hi=1), PURGE; fan_on drops exactly 3 sec_ticks later and the state is STANDBY.
REQ-037 In HEAT1, timer key pressed x3 -> remain_s 2, 4, 5 (saturated). After 5 sec_ticks: timer_active=0, heat_lo=0, state PURGE.
REQ-038 In HEAT2, power pulse -> PURGE with off_pending. A heat pulse during PURGE is ignored. After 3 ticks: OFF, light_on=0.
REQ-039 key_pulse=5'b00011 in STANDBY -> OFF (power wins); key_pulse=5'b00110 in STANDBY -> HEAT1 (heat beats fan).
REQ-040 In VENT with a timer set, light toggled, then rst asserted -> next cycle all outputs 0 and remain_s=0.
REQ-041 In OFF, heat/fan/light/timer pulses -> no output change.
